// File: rtl/tx_uart.sv
`default_nettype none
// ============================================================================
//  Module      : tx_uart
//  Description : 8n1 UART transmitter with a circular transmit buffer of
//                2**LOG2_DEPTH bytes. Each bit lasts 16 baud strobes. Frames
//                leave back-to-back while the buffer holds data.
//  Revision    : 1.0  initial release
// ============================================================================
module tx_uart #(
    parameter int LOG2_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic       x16BaudStrobe,
    input  logic       write,
    input  logic [7:0] dataIn,
    output logic       serialOut,
    output logic       busy,
    output logic       dataPresent,
    output logic       halfFull,
    output logic       full,
    output logic       overflow
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    // Pointers need at least one bit; with DEPTH=1 they never leave zero.
    localparam int PW    = (LOG2_DEPTH > 0) ? LOG2_DEPTH : 1;
    localparam int CW    = LOG2_DEPTH + 1;

    localparam logic [CW-1:0] C_FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] C_HALF_CNT = CW'(DEPTH / 2);
    localparam logic [PW-1:0] C_LAST_PTR = PW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      div_q, div_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      sh_q, sh_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;

    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            present_q, present_d;
    logic            half_q, half_d;
    logic            full_q, full_d;
    logic            ovf_q, ovf_d;

    logic [7:0]      mem [DEPTH];
    logic [7:0]      head_byte;
    logic            can_pop;
    logic            pop;
    logic            push;

    // Advance a pointer, wrapping modulo DEPTH.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == C_LAST_PTR) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    assign head_byte = mem[rd_ptr_q];
    // The registered flag gates the pop, so a fresh byte needs two edges to start.
    assign can_pop   = present_q && (count_q != '0);

    // Serialiser: next state, shift register, bit counter and line level.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        sh_d      = sh_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                div_d  = '0;
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (x16BaudStrobe && can_pop) begin
                    pop     = 1'b1;
                    sh_d    = head_byte;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (x16BaudStrobe) begin
                    div_d = div_q + 4'd1;
                    if (div_q == 4'd15) begin
                        tx_d      = sh_q[0];
                        bit_cnt_d = '0;
                        state_d   = DATA;
                    end
                end
            end
            DATA: begin
                if (x16BaudStrobe) begin
                    div_d = div_q + 4'd1;
                    if (div_q == 4'd15) begin
                        sh_d = {1'b0, sh_q[7:1]};
                        if (bit_cnt_q != 3'd7) begin
                            tx_d      = sh_q[1];
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end
                    end
                end
            end
            STOP: begin
                if (x16BaudStrobe) begin
                    div_d = div_q + 4'd1;
                    if (div_q == 4'd15) begin
                        if (can_pop) begin
                            // div wraps to zero, so the next start bit is a full 16 strobes
                            pop     = 1'b1;
                            sh_d    = head_byte;
                            tx_d    = 1'b0;
                            state_d = START;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Buffer bookkeeping: a same-cycle pop frees the slot a full-buffer write needs.
    always_comb begin
        push      = write && ((count_q != C_FULL_CNT) || pop);
        rd_ptr_d  = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d  = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ovf_d     = ovf_q || (write && !push);
        // Flags follow the count one clock later.
        present_d = (count_q != '0);
        half_d    = (LOG2_DEPTH == 0) ? (count_q != '0) : (count_q >= C_HALF_CNT);
        full_d    = (count_q == C_FULL_CNT);
    end

    // State, datapath and buffer control registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_cnt_q <= '0;
            sh_q      <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            present_q <= 1'b0;
            half_q    <= 1'b0;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            sh_q      <= sh_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            present_q <= present_d;
            half_q    <= half_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
        end
    end

    // Buffer storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= dataIn;
        end
    end

    assign serialOut   = tx_q;
    assign busy        = busy_q;
    assign dataPresent = present_q;
    assign halfFull    = half_q;
    assign full        = full_q;
    assign overflow    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_uart.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tx_uart
//  Description : Scoreboard bench for tx_uart. The driver predicts which
//                writes the buffer accepts and queues them; a line monitor
//                decodes every strobe sample and compares whole frames.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tx_uart;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       stb = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] din = 8'h00;
    logic       wr0 = 1'b0;
    logic [7:0] din0 = 8'h00;

    logic so, bsy, dp, hf, fl, ov;
    logic so0, bsy0, dp0, hf0, fl0, ov0;

    tx_uart #(.LOG2_DEPTH(4)) dut (
        .clk(clk), .rstN(rstN), .x16BaudStrobe(stb), .write(wr), .dataIn(din),
        .serialOut(so), .busy(bsy), .dataPresent(dp), .halfFull(hf),
        .full(fl), .overflow(ov)
    );

    tx_uart #(.LOG2_DEPTH(0)) dut0 (
        .clk(clk), .rstN(rstN), .x16BaudStrobe(stb), .write(wr0), .dataIn(din0),
        .serialOut(so0), .busy(bsy0), .dataPresent(dp0), .halfFull(hf0),
        .full(fl0), .overflow(ov0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        int         stamp;
    } ent_t;

    ent_t       q[$];
    ent_t       cur;
    int         phase = -1;   // strobes since the current start edge, -1 when idle
    int         bad = -1;
    int         tests = 0;
    int         errors = 0;
    bit         stb_en = 1'b0;
    bit         stb_rand = 1'b0;
    int         sdiv = 0;
    bit         exp_ovf = 1'b0;
    bit         w0_next = 1'b0;
    logic [7:0] d0_next = 8'h00;

    function automatic void chk(input bit ok, input string name, input int act, input int exp);
        tests++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // One clock: drive strobe/write at negedge, predict acceptance, settle after posedge.
    task automatic step(input bit w, input logic [7:0] d);
        bit pp;
        int sz;
        @(negedge clk);
        if (!stb_en) stb = 1'b0;
        else if (stb_rand) stb = ($urandom_range(0, 2) == 0);
        else begin
            stb  = (sdiv == 3);
            sdiv = (sdiv + 1) % 4;
        end
        wr      = w;
        din     = w ? d : 8'($urandom);
        wr0     = w0_next;
        din0    = d0_next;
        w0_next = 1'b0;
        if (w && rstN) begin
            // A frame starts on a strobe at least two clocks after its byte was written.
            pp = stb && (phase < 0 || phase == 159) && q.size() > 0 && q[0].stamp + 2 <= cyc;
            sz = q.size() - (pp ? 1 : 0);
            if (sz < DEPTH) q.push_back('{d, cyc});
            else exp_ovf = 1'b1;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((q.size() > 0 || phase >= 0) && n < limit) begin
            step(1'b0, 8'h00);
            n++;
        end
        chk(n < limit, "drain_timeout", n, limit);
    endtask

    // Line monitor: one sample per strobe; frame = 0, d[0..7], 1, each 16 samples.
    always @(posedge clk) begin
        int s;
        int b;
        logic smp;
        logic expbit;
        #1;
        if (rstN && stb) begin
            s   = cyc - 1;
            smp = so;
            if (phase < 0 || phase == 159) begin
                if (q.size() > 0 && q[0].stamp + 2 <= s) begin
                    cur = q.pop_front();
                    chk(smp == 1'b0 && bsy == 1'b1, "start_bit", {smp, bsy}, 2'b01);
                    phase = 0;
                    bad   = -1;
                end else begin
                    if (phase == 159) chk(smp == 1'b1 && bsy == 1'b0, "frame_end_idle", {smp, bsy}, 2'b10);
                    else              chk(smp == 1'b1 && bsy == 1'b0, "idle_line", {smp, bsy}, 2'b10);
                    phase = -1;
                end
            end else begin
                phase++;
                b = phase / 16;
                if (b == 0)      expbit = 1'b0;
                else if (b == 9) expbit = 1'b1;
                else             expbit = cur.d[b-1];
                if ((smp !== expbit || bsy !== 1'b1) && bad < 0) bad = phase;
                if (phase == 159) chk(bad < 0, "frame_byte", bad, cur.d);
            end
        end
    end

    initial begin
        int n;
        bit ok;
        logic [7:0] v;

        // 1: reset values, then 1000 idle clocks with strobes every 4 clocks
        repeat (3) step(1'b0, 8'h00);
        chk(so == 1'b1 && bsy == 1'b0, "reset_line", {so, bsy}, 2'b10);
        chk({dp, hf, fl, ov} == 4'b0000, "reset_flags", {dp, hf, fl, ov}, 0);
        rstN   = 1'b1;
        stb_en = 1'b1;
        ok     = 1'b1;
        repeat (1000) begin
            step(1'b0, 8'h00);
            if (so !== 1'b1 || bsy !== 1'b0 || {dp, hf, fl, ov} !== 4'b0000) ok = 1'b0;
        end
        chk(ok, "idle_1000", ok, 1);

        // 2: single byte 0xA5
        step(1'b1, 8'hA5);
        wait_idle(2000);
        chk(dp == 1'b0 && bsy == 1'b0, "a5_done", {dp, bsy}, 0);

        // 3: fill all 16 slots with strobes stopped, then overflow with 0xEE
        stb_en = 1'b0;
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i));
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        chk({dp, hf, fl, ov} == 4'b1110, "full_flags", {dp, hf, fl, ov}, 4'b1110);
        step(1'b1, 8'hEE);
        chk(ov == 1'b1, "overflow_set", ov, 1);
        stb_en = 1'b1;
        sdiv   = 0;
        wait_idle(12000);
        chk(ov == exp_ovf, "overflow_sticky", ov, exp_ovf);

        // 4: 8 queued bytes, then a write lands on the same clock as the first pop
        stb_en = 1'b0;
        for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom));
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        chk({hf, fl} == 2'b10, "half_8", {hf, fl}, 2'b10);
        stb_en = 1'b1;
        while (sdiv != 3) step(1'b0, 8'h00);
        step(1'b1, 8'h5A);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        chk({dp, hf, fl} == 3'b110, "pushpop_count8", {dp, hf, fl}, 3'b110);
        wait_idle(7000);

        // random traffic: irregular strobes, bursty writes, fills and overflows
        stb_rand = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            v = 8'($urandom);
            step($urandom_range(0, 15) == 0, v);
        end
        chk(ov == exp_ovf, "random_overflow", ov, exp_ovf);

        // 5: reset at strobe 70 of a frame
        n = 0;
        while (phase != 70 && n < 3000) begin
            step(1'b0, 8'h00);
            n++;
        end
        chk(n < 3000, "phase70_timeout", n, 3000);
        @(negedge clk);
        rstN    = 1'b0;
        q.delete();
        phase   = -1;
        exp_ovf = 1'b0;
        #1;
        chk(so == 1'b1 && bsy == 1'b0, "reset_midframe", {so, bsy}, 2'b10);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        chk({dp, hf, fl, ov} == 4'b0000, "reset_flushed", {dp, hf, fl, ov}, 0);
        rstN     = 1'b1;
        stb_rand = 1'b0;
        step(1'b1, 8'h3C);
        wait_idle(2000);

        // 6: single holding register
        stb_en  = 1'b0;
        w0_next = 1'b1;
        d0_next = 8'h81;
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        chk({dp0, hf0, fl0, ov0} == 4'b1110, "d0_hold_flags", {dp0, hf0, fl0, ov0}, 4'b1110);
        stb_en = 1'b1;
        sdiv   = 0;
        n      = 0;
        while (bsy0 !== 1'b1 && n < 100) begin
            step(1'b0, 8'h00);
            n++;
        end
        chk(bsy0 == 1'b1 && so0 == 1'b0, "d0_start", {bsy0, so0}, 2'b10);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        chk({dp0, fl0} == 2'b00, "d0_popped", {dp0, fl0}, 0);
        w0_next = 1'b1;
        d0_next = 8'h42;
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        chk({fl0, ov0} == 2'b10, "d0_second_accepted", {fl0, ov0}, 2'b10);
        w0_next = 1'b1;
        d0_next = 8'h99;
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        chk(ov0 == 1'b1, "d0_overflow", ov0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
